// File: rtl/link_pkg.sv
// Framing constants and receiver state encoding shared by both ends of the
// single-wire frame link.
package link_pkg;

  localparam int   FRAME_WIDTH = 40;
  localparam logic START_BIT   = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b0;

  typedef enum logic [1:0] {
    ARM,
    IDLE,
    DATA
  } rxState_t;

endpackage

// File: rtl/serial_receiver_bit_sync.sv
// Flop chain that brings the serial line into the receiver clock domain.
// It is instantiated only when at least one stage is wanted.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Plain shift chain: stage 0 takes the raw line and the last stage feeds the receiver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/serial_receiver.sv
// Recovers start-bit framed words from the single-wire link and presents them
// on a valid/ready port backed by a one-entry holding register.
module serial_receiver
  import link_pkg::*;
#(
  parameter int WIDTH       = FRAME_WIDTH,
  parameter int SYNC_STAGES = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic [CNT_W-1:0] frame_count
);

  localparam int               BIT_CW   = $clog2(WIDTH);
  localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(WIDTH - 1);

  logic s;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (sin),
        .q_o  (s)
      );
    end else begin : g_nosync
      assign s = sin;
    end
  endgenerate

  rxState_t          state_q, state_d;
  // The oldest shifted bit is always pushed out before it is read, so only WIDTH-1 bits are kept.
  logic [WIDTH-2:0]  shReg_q, shReg_d;
  logic [BIT_CW-1:0] bitCnt_q, bitCnt_d;
  logic [WIDTH-1:0]  outData_q, outData_d;
  logic              outValid_q, outValid_d;
  logic              overrun_q, overrun_d;
  logic [CNT_W-1:0]  frameCount_q, frameCount_d;

  logic [WIDTH-1:0]  frameWord;
  logic              frameDone;
  logic              load;

  assign frameWord = {shReg_q, s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARM;
      shReg_q      <= '0;
      bitCnt_q     <= '0;
      outData_q    <= '0;
      outValid_q   <= 1'b0;
      overrun_q    <= 1'b0;
      frameCount_q <= '0;
    end else begin
      state_q      <= state_d;
      shReg_q      <= shReg_d;
      bitCnt_q     <= bitCnt_d;
      outData_q    <= outData_d;
      outValid_q   <= outValid_d;
      overrun_q    <= overrun_d;
      frameCount_q <= frameCount_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shReg_d      = shReg_q;
    bitCnt_d     = bitCnt_q;
    outData_d    = outData_q;
    outValid_d   = outValid_q;
    overrun_d    = overrun_q;
    frameCount_d = frameCount_q;
    frameDone    = 1'b0;
    load         = 1'b0;

    // ARM insists on an idle level first, so a line caught high is never framed.
    case (state_q)
      ARM: begin
        if (s == IDLE_LEVEL) state_d = IDLE;
      end
      IDLE: begin
        if (s == START_BIT) begin
          state_d  = DATA;
          bitCnt_d = '0;
        end
      end
      DATA: begin
        shReg_d  = frameWord[WIDTH-2:0];
        bitCnt_d = bitCnt_q + 1'b1;
        if (bitCnt_q == LAST_BIT) begin
          frameDone = 1'b1;
          bitCnt_d  = '0;
          state_d   = ARM;
        end
      end
      default: state_d = ARM;
    endcase

    // A holding register drained on this same edge counts as free.
    load = frameDone && (!outValid_q || out_ready);

    if (outValid_q && out_ready) outValid_d = 1'b0;
    if (load) begin
      outData_d    = frameWord;
      outValid_d   = 1'b1;
      frameCount_d = frameCount_q + 1'b1;
    end

    if (overrun_clr) overrun_d = 1'b0;
    if (frameDone && !load) overrun_d = 1'b1;
  end

  assign out_data    = outData_q;
  assign out_valid   = outValid_q;
  assign busy        = (state_q == DATA);
  assign overrun     = overrun_q;
  assign frame_count = frameCount_q;

endmodule
